// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, write-back control
// bit positions and the iterative multiplier's state encoding.
package ex_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11,
    ALU_MUL  = 4'd12
  } alu_op_e;

  // Bit positions inside the 2-bit write-back control field.
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  // LUI places the immediate in the upper half of a 32-bit word.
  localparam int LUI_SHIFT = 16;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/ex_mul_iter.sv
// Radix-2 shift-add multiplier. One partial product per cycle, XLEN cycles
// in BUSY, then DONE until the consumer is not holding. Returns the low XLEN
// bits of the product (wraps mod 2^XLEN). abort returns to IDLE at once.
module ex_mul_iter
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            hold,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  mul_state_e      state_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] mcand_q;
  logic [XLEN-1:0] mplier_q;
  logic            busy_q;
  logic            done_q;

  // Multiplier FSM and datapath: capture, iterate, present, release.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state_q  <= MUL_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        MUL_IDLE: begin
          if (start) begin
            state_q  <= MUL_BUSY;
            cnt_q    <= CW'(XLEN - 1);
            acc_q    <= '0;
            mcand_q  <= a;
            mplier_q <= b;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
          end
        end
        MUL_BUSY: begin
          // Iterates even while downstream holds; only DONE waits.
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          if (cnt_q == '0) begin
            state_q <= MUL_DONE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        MUL_DONE: begin
          if (!hold) begin
            state_q <= MUL_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= MUL_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = acc_q;

endmodule

// File: rtl/ex_stage_pipe.sv
// Execute stage: operand forwarding, ALU, ALU-src / destination muxes,
// iterative multiplier hookup and the EX/MEM pipeline register.
// Optional build macro EX_OVF_TRAP_EN: flags signed ADD/SUB overflow on
// exm_ovf and suppresses the register write and store of that instruction.
module ex_stage_pipe
  import ex_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              ex_ready,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic [OP_W-1:0]   id_alu_op,
  input  logic [1:0]        id_wb,
  input  logic              id_mem_rd,
  input  logic              id_mem_wr,
  input  logic              id_branch,
  input  logic              flush,
  input  logic              mem_stall,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              exm_valid,
  output logic [1:0]        exm_wb,
  output logic              exm_mem_rd,
  output logic              exm_mem_wr,
  output logic              exm_branch,
  output logic              exm_zero,
  output logic [XLEN-1:0]   exm_alu_result,
  output logic [XLEN-1:0]   exm_store_data,
  output logic [REG_AW-1:0] exm_dest,
  output logic              exm_ovf
);

  localparam int SHW = $clog2(XLEN);

  typedef struct packed {
    logic              valid;
    logic [1:0]        wb;
    logic              mem_rd;
    logic              mem_wr;
    logic              branch;
    logic              zero;
    logic              ovf;
    logic [XLEN-1:0]   result;
    logic [XLEN-1:0]   store;
    logic [REG_AW-1:0] dest;
  } exm_t;

  exm_t            exm_q, exm_d;
  exm_t            mul_ctl_q, mul_ctl_d;
  exm_t            alu_entry;
  alu_op_e         op;
  logic [XLEN-1:0] fwd_a, fwd_b, op_b, alu_res, mul_result;
  logic [SHW-1:0]  shamt;
  logic            ovf_trap;
  logic            mul_start, mul_busy, mul_done;

  // EX/MEM beats WB; r0 and loads still in EX/MEM never forward.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [REG_AW-1:0] addr,
    input logic [XLEN-1:0]   rf_val,
    input exm_t              ex,
    input logic              wb_we,
    input logic [REG_AW-1:0] wb_addr,
    input logic [XLEN-1:0]   wb_val
  );
    if (addr == '0)
      return rf_val;
    if (ex.valid && ex.wb[WB_REGWRITE] && !ex.mem_rd && ex.dest == addr)
      return ex.result;
    if (wb_we && wb_addr == addr)
      return wb_val;
    return rf_val;
  endfunction

  assign op    = alu_op_e'(id_alu_op);
  assign fwd_a = fwd_sel(id_rs, id_rs1_data, exm_q, wb_regwrite, wb_rd, wb_data);
  assign fwd_b = fwd_sel(id_rt, id_rs2_data, exm_q, wb_regwrite, wb_rd, wb_data);
  assign op_b  = id_alu_src ? id_imm : fwd_b;
  assign shamt = op_b[SHW-1:0];

  // Single-cycle ALU and signed-overflow detection.
  // NOTE: every always_comb output gets a default first, so no path through
  // the case can leave a value unassigned and infer a latch.
  always_comb begin
    alu_res  = '0;
    ovf_trap = 1'b0;
    case (op)
      ALU_ADD:  alu_res = fwd_a + op_b;
      ALU_SUB:  alu_res = fwd_a - op_b;
      ALU_AND:  alu_res = fwd_a & op_b;
      ALU_OR:   alu_res = fwd_a | op_b;
      ALU_XOR:  alu_res = fwd_a ^ op_b;
      ALU_NOR:  alu_res = ~(fwd_a | op_b);
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (fwd_a < op_b)};
      ALU_SLL:  alu_res = fwd_a << shamt;
      ALU_SRL:  alu_res = fwd_a >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(fwd_a) >>> shamt);
      ALU_LUI:  alu_res = op_b << LUI_SHIFT;
      default:  alu_res = '0;  // MUL result comes from the iterative unit
    endcase
`ifdef EX_OVF_TRAP_EN
    if (op == ALU_ADD)
      ovf_trap = (fwd_a[XLEN-1] == op_b[XLEN-1]) && (alu_res[XLEN-1] != fwd_a[XLEN-1]);
    else if (op == ALU_SUB)
      ovf_trap = (fwd_a[XLEN-1] != op_b[XLEN-1]) && (alu_res[XLEN-1] != fwd_a[XLEN-1]);
`endif
  end

  // EX/MEM entry for the instruction currently in ID/EX.
  always_comb begin
    alu_entry                  = '0;
    alu_entry.valid            = 1'b1;
    alu_entry.wb               = id_wb;
    alu_entry.wb[WB_REGWRITE]  = id_wb[WB_REGWRITE] & ~ovf_trap;
    alu_entry.mem_rd           = id_mem_rd;
    alu_entry.mem_wr           = id_mem_wr & ~ovf_trap;
    alu_entry.branch           = id_branch;
    alu_entry.zero             = (alu_res == '0);
    alu_entry.ovf              = ovf_trap;
    alu_entry.result           = alu_res;
    alu_entry.store            = fwd_b;
    alu_entry.dest             = id_reg_dst ? id_rd : id_rt;
  end

  // EX/MEM next state in priority order: flush, stall, MUL result,
  // MUL in flight, MUL accept, single-cycle op, bubble.
  always_comb begin
    exm_d     = exm_q;
    mul_start = 1'b0;
    if (flush) begin
      exm_d = '0;
    end else if (mem_stall) begin
      exm_d = exm_q;
    end else if (mul_done) begin
      exm_d        = mul_ctl_q;
      exm_d.valid  = 1'b1;
      exm_d.result = mul_result;
      exm_d.zero   = (mul_result == '0);
    end else if (mul_busy) begin
      exm_d = '0;
    end else if (id_valid && op == ALU_MUL) begin
      exm_d     = '0;
      mul_start = 1'b1;
    end else if (id_valid) begin
      exm_d = alu_entry;
    end else begin
      exm_d = '0;
    end
  end

  assign mul_ctl_d = mul_start ? alu_entry : mul_ctl_q;

  // EX/MEM pipeline register.
  always_ff @(posedge clk) begin
    if (rst) exm_q <= '0;
    else     exm_q <= exm_d;
  end

  // Control and destination of the MUL in flight, replayed at completion.
  always_ff @(posedge clk) begin
    if (rst) mul_ctl_q <= '0;
    else     mul_ctl_q <= mul_ctl_d;
  end

  ex_mul_iter #(.XLEN(XLEN)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .abort  (flush),
    .hold   (mem_stall),
    .a      (fwd_a),
    .b      (op_b),
    .busy   (mul_busy),
    .done   (mul_done),
    .result (mul_result)
  );

  assign ex_ready       = flush | (~mem_stall & ~mul_busy);
  assign exm_valid      = exm_q.valid;
  assign exm_wb         = exm_q.wb;
  assign exm_mem_rd     = exm_q.mem_rd;
  assign exm_mem_wr     = exm_q.mem_wr;
  assign exm_branch     = exm_q.branch;
  assign exm_zero       = exm_q.zero;
  assign exm_alu_result = exm_q.result;
  assign exm_store_data = exm_q.store;
  assign exm_dest       = exm_q.dest;
  assign exm_ovf        = exm_q.ovf;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Directed bench for ex_stage_pipe: a vector table for the single-cycle ALU
// plus hand sequences for forwarding, r0, MUL latency, flush and mem_stall.
module tb_ex_stage_pipe;
  import ex_pkg::*;

`ifdef EX_OVF_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, ex_ready;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_alu_src, id_reg_dst;
  logic [3:0]  id_alu_op;
  logic [1:0]  id_wb;
  logic        id_mem_rd, id_mem_wr, id_branch;
  logic        flush, mem_stall;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exm_valid, exm_mem_rd, exm_mem_wr, exm_branch, exm_zero, exm_ovf;
  logic [1:0]  exm_wb;
  logic [31:0] exm_alu_result, exm_store_data;
  logic [4:0]  exm_dest;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ex_stage_pipe #(.XLEN(32), .REG_AW(5), .OP_W(4)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .ex_ready(ex_ready),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_alu_op(id_alu_op),
    .id_wb(id_wb), .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr),
    .id_branch(id_branch), .flush(flush), .mem_stall(mem_stall),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .exm_valid(exm_valid), .exm_wb(exm_wb), .exm_mem_rd(exm_mem_rd),
    .exm_mem_wr(exm_mem_wr), .exm_branch(exm_branch), .exm_zero(exm_zero),
    .exm_alu_result(exm_alu_result), .exm_store_data(exm_store_data),
    .exm_dest(exm_dest), .exm_ovf(exm_ovf)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock edge, then settle away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic src);
    id_valid    = 1'b1;
    id_alu_op   = op;
    id_rs       = rs;
    id_rt       = rt;
    id_rd       = rd;
    id_rs1_data = a;
    id_rs2_data = b;
    id_imm      = imm;
    id_alu_src  = src;
    id_reg_dst  = 1'b1;
    id_wb       = 2'b10;
    id_mem_rd   = 1'b0;
    id_mem_wr   = 1'b0;
    id_branch   = 1'b0;
    wb_regwrite = 1'b0;
    wb_rd       = '0;
    wb_data     = '0;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic        src;
    logic        reg_dst;
    logic        ovf_case;
    logic [31:0] exp_res;
    logic [4:0]  exp_dest;
  } vec_t;

  vec_t vecs[15];

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat, low, bad, seen;
    logic [1:0] exp_wb;

    vecs[0]  = '{ALU_ADD,  32'd5,         32'd7,         32'd0,      1'b0, 1'b1, 1'b0, 32'd12,        5'd9};
    vecs[1]  = '{ALU_SUB,  32'd5,         32'd5,         32'd0,      1'b0, 1'b1, 1'b0, 32'd0,         5'd9};
    vecs[2]  = '{ALU_AND,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'd0,      1'b0, 1'b1, 1'b0, 32'h00F0_1234, 5'd9};
    vecs[3]  = '{ALU_OR,   32'hF000_0000, 32'h0000_000F, 32'd0,      1'b0, 1'b1, 1'b0, 32'hF000_000F, 5'd9};
    vecs[4]  = '{ALU_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'd0,      1'b0, 1'b1, 1'b0, 32'hF0F0_0F0F, 5'd9};
    vecs[5]  = '{ALU_NOR,  32'hF000_0000, 32'h0000_000F, 32'd0,      1'b0, 1'b1, 1'b0, 32'h0FFF_FFF0, 5'd9};
    vecs[6]  = '{ALU_SLT,  32'hFFFF_FFFF, 32'd1,         32'd0,      1'b0, 1'b1, 1'b0, 32'd1,         5'd9};
    vecs[7]  = '{ALU_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0,      1'b0, 1'b1, 1'b0, 32'd0,         5'd9};
    vecs[8]  = '{ALU_SLL,  32'd1,         32'h0000_DEAD, 32'd31,     1'b1, 1'b1, 1'b0, 32'h8000_0000, 5'd9};
    vecs[9]  = '{ALU_SLL,  32'd3,         32'h0000_0021, 32'd0,      1'b0, 1'b1, 1'b0, 32'd6,         5'd9};
    vecs[10] = '{ALU_SRL,  32'h8000_0000, 32'd4,         32'd0,      1'b0, 1'b1, 1'b0, 32'h0800_0000, 5'd9};
    vecs[11] = '{ALU_SRA,  32'h8000_0000, 32'd4,         32'd0,      1'b0, 1'b1, 1'b0, 32'hF800_0000, 5'd9};
    vecs[12] = '{ALU_LUI,  32'd0,         32'd0,         32'h1234,   1'b1, 1'b1, 1'b0, 32'h1234_0000, 5'd9};
    vecs[13] = '{ALU_ADD,  32'h7FFF_FFFF, 32'd1,         32'd0,      1'b0, 1'b1, 1'b1, 32'h8000_0000, 5'd9};
    vecs[14] = '{ALU_SUB,  32'h8000_0000, 32'd1,         32'd0,      1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF, 5'd2};

    // Reset wins over a valid instruction presented at the same time.
    rst = 1'b1; flush = 1'b0; mem_stall = 1'b0;
    instr(ALU_ADD, 5'd1, 5'd2, 5'd9, 32'd1, 32'd1, 32'd0, 1'b0);
    id_wb = 2'b11; id_mem_wr = 1'b1;
    step(); step();
    check("rst_valid",  exm_valid,      1'b0);
    check("rst_result", exm_alu_result, 32'd0);
    check("rst_wb",     exm_wb,         2'b00);
    check("rst_mem_wr", exm_mem_wr,     1'b0);
    check("rst_dest",   exm_dest,       5'd0);
    check("rst_ready",  ex_ready,       1'b1);
    rst = 1'b0;

    // Single-cycle ALU table: rs=1, rt=2, no forwarding between vectors.
    for (int i = 0; i < 15; i++) begin
      instr(vecs[i].op, 5'd1, 5'd2, 5'd9, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].src);
      id_reg_dst = vecs[i].reg_dst;
      step();
      exp_wb = (vecs[i].ovf_case && TRAP) ? 2'b00 : 2'b10;
      check($sformatf("vec%0d_result", i), exm_alu_result, vecs[i].exp_res);
      check($sformatf("vec%0d_zero", i),   exm_zero,       vecs[i].exp_res == 32'd0);
      check($sformatf("vec%0d_dest", i),   exm_dest,       vecs[i].exp_dest);
      check($sformatf("vec%0d_valid", i),  exm_valid,      1'b1);
      check($sformatf("vec%0d_wb", i),     exm_wb,         exp_wb);
      check($sformatf("vec%0d_ovf", i),    exm_ovf,        vecs[i].ovf_case && TRAP);
    end

    // Forwarding priority: EX/MEM beats WB; loads in EX/MEM are skipped.
    instr(ALU_ADD, 5'd0, 5'd0, 5'd3, 32'h11, 32'd0, 32'd0, 1'b0);
    step();
    check("fwd_producer", exm_alu_result, 32'h11);
    instr(ALU_ADD, 5'd3, 5'd0, 5'd4, 32'h99, 32'd0, 32'd0, 1'b0);
    wb_regwrite = 1'b1; wb_rd = 5'd3; wb_data = 32'h22;
    step();
    check("fwd_ex_beats_wb", exm_alu_result, 32'h11);
    instr(ALU_ADD, 5'd0, 5'd0, 5'd3, 32'h11, 32'd0, 32'd0, 1'b0);
    id_mem_rd = 1'b1; id_wb = 2'b11;
    step();
    check("fwd_load_mem_rd", exm_mem_rd, 1'b1);
    instr(ALU_ADD, 5'd3, 5'd0, 5'd4, 32'h99, 32'd0, 32'd0, 1'b0);
    wb_regwrite = 1'b1; wb_rd = 5'd3; wb_data = 32'h22;
    step();
    check("fwd_load_skipped", exm_alu_result, 32'h22);
    instr(ALU_ADD, 5'd0, 5'd4, 5'd5, 32'd0, 32'h77, 32'd5, 1'b1);
    step();
    check("fwd_imm_result", exm_alu_result, 32'd5);
    check("fwd_store_data", exm_store_data, 32'h22);
    instr(ALU_ADD, 5'd6, 5'd0, 5'd7, 32'd1, 32'd0, 32'd0, 1'b0);
    wb_regwrite = 1'b1; wb_rd = 5'd6; wb_data = 32'h30;
    step();
    check("fwd_wb_only", exm_alu_result, 32'h30);

    // Register zero never takes a forwarded value.
    instr(ALU_ADD, 5'd0, 5'd0, 5'd0, 32'h55, 32'd0, 32'd0, 1'b0);
    step();
    check("r0_producer_dest", exm_dest, 5'd0);
    instr(ALU_ADD, 5'd0, 5'd0, 5'd7, 32'd0, 32'd0, 32'd0, 1'b0);
    wb_regwrite = 1'b1; wb_rd = 5'd0; wb_data = 32'h66;
    step();
    check("r0_result", exm_alu_result, 32'd0);
    check("r0_zero",   exm_zero,       1'b1);

    // MUL 7 x -3: 33 edges to result, ready low and bubbles meanwhile.
    instr(ALU_MUL, 5'd1, 5'd2, 5'd8, 32'd7, 32'hFFFF_FFFD, 32'd0, 1'b0);
    check("mul_accept_ready", ex_ready, 1'b1);
    step();
    lat = 0; low = 0; bad = 0;
    while (exm_valid !== 1'b1 && lat < 60) begin
      if (ex_ready === 1'b0) low++;
      if (exm_wb !== 2'b00) bad++;
      step();
      lat++;
    end
    id_valid = 1'b0;
    check("mul_latency",       lat,            33);
    check("mul_ready_low",     low,            33);
    check("mul_bubble_ctrl",   bad,            0);
    check("mul_result",        exm_alu_result, 32'hFFFF_FFEB);
    check("mul_dest",          exm_dest,       5'd8);
    check("mul_wb",            exm_wb,         2'b10);
    check("mul_store_data",    exm_store_data, 32'hFFFF_FFFD);
    check("mul_ready_after",   ex_ready,       1'b1);
    step();
    check("mul_no_reissue",    exm_valid,      1'b0);

    // Flush in cycle 10 of a MUL aborts it; no result ever appears.
    instr(ALU_MUL, 5'd1, 5'd2, 5'd12, 32'd7, 32'd5, 32'd0, 1'b0);
    step();
    for (int c = 0; c < 9; c++) step();
    flush = 1'b1;
    #1;
    check("flush_cycle_ready", ex_ready, 1'b1);
    step();
    flush = 1'b0; id_valid = 1'b0;
    check("flush_valid", exm_valid, 1'b0);
    check("flush_ready", ex_ready,  1'b1);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (exm_valid === 1'b1) seen++;
    end
    check("flush_no_mul_result", seen, 0);

    // mem_stall holds EX/MEM for three edges; the held-off op lands after.
    instr(ALU_ADD, 5'd1, 5'd2, 5'd10, 32'h100, 32'h23, 32'd0, 1'b0);
    step();
    check("stall_pre_result", exm_alu_result, 32'h123);
    instr(ALU_ADD, 5'd1, 5'd2, 5'd11, 32'h200, 32'd1, 32'd0, 1'b0);
    mem_stall = 1'b1;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (exm_valid !== 1'b1 || exm_alu_result !== 32'h123 || exm_dest !== 5'd10 ||
          exm_wb !== 2'b10 || exm_store_data !== 32'h23 || ex_ready !== 1'b0) bad++;
    end
    check("stall_hold", bad, 0);
    mem_stall = 1'b0;
    step();
    check("stall_release_result", exm_alu_result, 32'h201);
    check("stall_release_dest",   exm_dest,       5'd11);

    // Flush with mem_stall loads a bubble.
    instr(ALU_ADD, 5'd1, 5'd2, 5'd13, 32'd1, 32'd1, 32'd0, 1'b0);
    mem_stall = 1'b1; flush = 1'b1;
    #1;
    check("flush_stall_ready", ex_ready, 1'b1);
    step();
    flush = 1'b0; mem_stall = 1'b0;
    check("flush_stall_valid", exm_valid, 1'b0);
    check("flush_stall_wb",    exm_wb,    2'b00);

    // Invalid instruction: bubble with all control bits clear.
    instr(ALU_ADD, 5'd1, 5'd2, 5'd14, 32'd2, 32'd3, 32'd0, 1'b0);
    id_valid = 1'b0; id_wb = 2'b11; id_mem_wr = 1'b1; id_branch = 1'b1;
    step();
    check("invalid_valid",  exm_valid,  1'b0);
    check("invalid_wb",     exm_wb,     2'b00);
    check("invalid_mem_wr", exm_mem_wr, 1'b0);
    check("invalid_branch", exm_branch, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
